// File: rtl/param_bank_staged_pkg.sv
// Shared definitions for the staged parameter bank: IEEE-754 default
// constants for the model cores, well-known slot indices, the commit FSM
// state type and a small word-assembly helper.
package param_bank_staged_pkg;

  localparam int DATA_W = 32;

  // IEEE-754 single-precision constants used as parameter defaults
  localparam logic [DATA_W-1:0] IEEE_1       = 32'h3F80_0000;
  localparam logic [DATA_W-1:0] PPS_COEF_DEF = 32'h3F66_6666;
  localparam logic [DATA_W-1:0] GAMMA_DEF    = 32'h42A0_0000;
  localparam logic [DATA_W-1:0] BDAMP1_DEF   = 32'h3E71_4120;
  localparam logic [DATA_W-1:0] BDAMP2_DEF   = 32'h3D14_4674;
  localparam logic [DATA_W-1:0] BDAMPC_DEF   = 32'h3C58_44D0;

  // Slot indices of the parameters the model cores expect
  localparam int SLOT_GAMMA_DYN = 0;
  localparam int SLOT_GAMMA_STA = 1;
  localparam int SLOT_BDAMP1    = 2;
  localparam int SLOT_BDAMP2    = 3;
  localparam int SLOT_BDAMPC    = 4;
  localparam int SLOT_PPS_COEF  = 5;
  localparam int SLOT_GAIN      = 6;
  localparam int SLOT_CLK_HALF  = 7;

  // Commit FSM: IDLE has nothing pending, ARMED waits for a tick,
  // HOLD has seen a tick while frozen and commits as soon as freeze drops
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } bank_state_t;

  // The host delivers each 32-bit word as two 16-bit wire halves
  function automatic logic [DATA_W-1:0] pack_word(input logic [15:0] hi,
                                                  input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/param_bank_staged_slot.sv
// One parameter slot: a shadow register loaded by the host trigger, an
// active register seen by the model cores, and a pending flag marking a
// shadow value that has not yet been committed.
module param_bank_staged_slot
  import param_bank_staged_pkg::*;
#(
  parameter int            DW        = DATA_W,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter bit            IMMEDIATE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          apply,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] shadow,
  output logic [DW-1:0] active,
  output logic          pending
);

  // Shadow/active/pending update; an apply always takes the shadow value
  // from before a same-cycle load, and that load stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= RESET_VAL;
      active  <= RESET_VAL;
      pending <= 1'b0;
    end else if (IMMEDIATE) begin
      if (load) begin
        shadow <= data;
        active <= data;
      end
      pending <= 1'b0;
    end else begin
      if (apply && pending) begin
        active <= shadow;
      end
      if (load) begin
        shadow  <= data;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_bank_staged.sv
// Double-buffered bank of trigger-loaded model parameters. Host writes
// land in per-slot shadows; every pending slot is copied to the active
// outputs together on a simulation-step tick so the model cores never
// see a half-updated parameter set. Also provides a registered readback
// of either the active or the shadow copy of any slot.
module param_bank_staged
  import param_bank_staged_pkg::*;
#(
  parameter int                  N_REG     = 16,
  parameter int                  DW        = DATA_W,
  parameter int                  SEL_W     = (N_REG > 1) ? $clog2(N_REG) : 1,
  parameter logic [N_REG*DW-1:0] DEFAULTS  = '0,
  parameter bit                  IMMEDIATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REG-1:0]    trig,
  input  logic [15:0]         wire_lo,
  input  logic [15:0]         wire_hi,
  input  logic                commit_tick,
  input  logic                freeze,
  input  logic [SEL_W-1:0]    rd_sel,
  input  logic                rd_shadow,
  output logic [N_REG*DW-1:0] params,
  output logic [DW-1:0]       rd_data,
  output logic [N_REG-1:0]    pending,
  output logic                commit_ack,
  output logic [15:0]         commit_cnt
);

  logic [DW-1:0]       data_word;
  logic [N_REG*DW-1:0] shadow_flat;
  logic [N_REG*DW-1:0] active_flat;
  logic [N_REG-1:0]    pending_vec;
  logic                any_trig;
  logic                apply;
  logic                commit_evt;
  logic [DW-1:0]       rd_next;
  bank_state_t         state_q;
  bank_state_t         state_d;

  assign data_word = DW'(pack_word(wire_hi, wire_lo));
  assign any_trig  = |trig;

  for (genvar i = 0; i < N_REG; i++) begin : g_slot
    param_bank_staged_slot #(
      .DW        (DW),
      .RESET_VAL (DEFAULTS[i*DW +: DW]),
      .IMMEDIATE (IMMEDIATE)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (trig[i]),
      .apply   (apply),
      .data    (data_word),
      .shadow  (shadow_flat[i*DW +: DW]),
      .active  (active_flat[i*DW +: DW]),
      .pending (pending_vec[i])
    );
  end

  // Commit FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM next state; a trigger arriving with the commit keeps us armed
  always_comb begin
    state_d = state_q;
    if (IMMEDIATE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_trig) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (commit_tick) begin
            if (freeze)        state_d = ST_HOLD;
            else if (any_trig) state_d = ST_ARMED;
            else               state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!freeze) state_d = any_trig ? ST_ARMED : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Commit FSM output: when the pending set is copied to the active outputs
  always_comb begin
    apply = 1'b0;
    if (!IMMEDIATE) begin
      case (state_q)
        ST_ARMED: apply = commit_tick && !freeze;
        ST_HOLD:  apply = !freeze;
        default:  apply = 1'b0;
      endcase
    end
    commit_evt = IMMEDIATE ? any_trig : apply;
  end

  // Acknowledge pulse and wrapping commit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_ack <= 1'b0;
      commit_cnt <= '0;
    end else begin
      commit_ack <= commit_evt;
      if (commit_evt) commit_cnt <= commit_cnt + 16'd1;
    end
  end

  // Readback select; out-of-range selects yield zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (int'(rd_sel) == i) begin
        rd_next = rd_shadow ? shadow_flat[i*DW +: DW] : active_flat[i*DW +: DW];
      end
    end
  end

  // Registered readback so no input reaches an output combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

  assign params  = active_flat;
  assign pending = pending_vec;

endmodule
